dmem_arbiter: RTL

Sequencer and two-way arbiter for the single data-memory port of the core. It accepts load/store requests from the core LSU and from the program loader, and grants them round-robin. Granted requests are forwarded as word-aligned memory transactions with byte enables and lane-shifted write data. It also extracts, sign- or zero-extends load data, flags misaligned accesses and times out unresponsive memory.

---
 rtl/dmem_arbiter.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and sequencer for the single data-memory port shared by
// the core LSU and the program loader; aligns stores, extends loads, times out.
module dmem_arbiter #(
  parameter int unsigned REG_LEN = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               c_req,
  input  logic               c_we,
  input  logic [REG_LEN-1:0] c_addr,
  input  logic [2:0]         c_type,
  input  logic [REG_LEN-1:0] c_wdata,
  output logic               c_gnt,
  output logic               c_rvalid,
  output logic [REG_LEN-1:0] c_rdata,
  output logic               c_err,
  input  logic               l_req,
  input  logic               l_we,
  input  logic [REG_LEN-1:0] l_addr,
  input  logic [2:0]         l_type,
  input  logic [REG_LEN-1:0] l_wdata,
  output logic               l_gnt,
  output logic               l_rvalid,
  output logic [REG_LEN-1:0] l_rdata,
  output logic               l_err,
  output logic               mem_req,
  output logic               mem_we,
  output logic [REG_LEN-1:0] mem_addr,
  output logic [3:0]         mem_be,
  output logic [REG_LEN-1:0] mem_wdata,
  input  logic               mem_gnt,
  input  logic               mem_rvalid,
  input  logic [REG_LEN-1:0] mem_rdata
);
  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, MREQ, MWAIT, RESP} state_t;
  state_t state, state_nx;

  logic               last;   // last granted owner, 1 = loader
  logic               own;    // owner of the access in flight, 1 = loader
  logic               we_q;
  logic [2:0]         typ;
  logic [1:0]         lane;
  logic [CNT_W-1:0]   cnt;
  logic               err_q;
  logic [REG_LEN-1:0] res_q;
  logic               timed_out;

  logic               pick_c, pick_l, pick_any, bad;
  logic               sel_we;
  logic [REG_LEN-1:0] sel_addr, sel_wdata, sel_shdata;
  logic [2:0]         sel_type;
  logic [1:0]         sel_lane;
  logic [3:0]         sel_be;
  logic [REG_LEN-1:0] rd_sh, rd_ext;

  // Arbitration, alignment check and lane placement of the candidate request
  always_comb begin
    pick_c    = rst_n && c_req && (!l_req || last);
    pick_l    = rst_n && l_req && (!c_req || !last);
    pick_any  = pick_c || pick_l;
    sel_we    = pick_l ? l_we    : c_we;
    sel_addr  = pick_l ? l_addr  : c_addr;
    sel_type  = pick_l ? l_type  : c_type;
    sel_wdata = pick_l ? l_wdata : c_wdata;
    sel_lane  = sel_addr[1:0];
    case (sel_type)
      3'b000, 3'b100: bad = 1'b0;
      3'b001, 3'b101: bad = sel_lane[0];
      3'b010:         bad = (sel_lane != 2'b00);
      default:        bad = 1'b1;
    endcase
    case (sel_type[1:0])
      2'b00:   sel_be = 4'b0001 << sel_lane;
      2'b01:   sel_be = 4'b0011 << sel_lane;
      default: sel_be = 4'b1111;
    endcase
    sel_shdata = sel_wdata << {sel_lane, 3'b000};
  end

  // Load result extraction from the returned word
  always_comb begin
    rd_sh = mem_rdata >> {lane, 3'b000};
    case (typ)
      3'b000:  rd_ext = {{(REG_LEN-8){rd_sh[7]}}, rd_sh[7:0]};
      3'b001:  rd_ext = {{(REG_LEN-16){rd_sh[15]}}, rd_sh[15:0]};
      3'b100:  rd_ext = {{(REG_LEN-8){1'b0}}, rd_sh[7:0]};
      3'b101:  rd_ext = {{(REG_LEN-16){1'b0}}, rd_sh[15:0]};
      default: rd_ext = mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    timed_out = (cnt == CNT_LAST);
    case (state)
      IDLE:  if (pick_any) state_nx = bad ? RESP : MREQ;
      MREQ:  if (mem_gnt) state_nx = MWAIT;
             else if (timed_out) state_nx = RESP;
      MWAIT: if (mem_rvalid || timed_out) state_nx = RESP;
      RESP:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Request fields, timeout counter and captured response
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last      <= 1'b1;
      own       <= 1'b0;
      we_q      <= 1'b0;
      typ       <= 3'b000;
      lane      <= 2'b00;
      cnt       <= '0;
      err_q     <= 1'b0;
      res_q     <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= 4'b0000;
      mem_wdata <= '0;
    end else begin
      if (state_nx != state)                    cnt <= '0;
      else if (state == MREQ || state == MWAIT) cnt <= cnt + CNT_W'(1);
      case (state)
        IDLE: if (pick_any) begin
          own   <= pick_l;
          last  <= pick_l;
          we_q  <= sel_we;
          typ   <= sel_type;
          lane  <= sel_lane;
          err_q <= bad;
          res_q <= '0;
          if (!bad) begin
            mem_req   <= 1'b1;
            mem_we    <= sel_we;
            mem_addr  <= {sel_addr[REG_LEN-1:2], 2'b00};
            mem_be    <= sel_we ? sel_be : 4'b1111;
            mem_wdata <= sel_we ? sel_shdata : '0;
          end
        end
        MREQ: if (state_nx != MREQ) begin
          mem_req   <= 1'b0;
          mem_we    <= 1'b0;
          mem_addr  <= '0;
          mem_be    <= 4'b0000;
          mem_wdata <= '0;
          err_q     <= (state_nx == RESP);
        end
        MWAIT: begin
          if (mem_rvalid)             res_q <= we_q ? '0 : rd_ext;
          else if (state_nx == RESP)  err_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Requester-side strobes: grant in IDLE, completion in RESP
  always_comb begin
    c_gnt    = 1'b0;
    l_gnt    = 1'b0;
    c_rvalid = 1'b0;
    l_rvalid = 1'b0;
    c_rdata  = '0;
    l_rdata  = '0;
    c_err    = 1'b0;
    l_err    = 1'b0;
    if (state == IDLE) begin
      c_gnt = pick_c;
      l_gnt = pick_l;
    end
    if (state == RESP) begin
      if (own) begin
        l_rvalid = 1'b1;
        l_rdata  = res_q;
        l_err    = err_q;
      end else begin
        c_rvalid = 1'b1;
        c_rdata  = res_q;
        c_err    = err_q;
      end
    end
  end
endmodule
